core_bus_arbiter: RTL
=====================

Name: core_bus_arbiter

Overview:
- Parametrised N-channel arbiter that merges the core's SRAM-like memory request channels (iram, dram, later more) onto one downstream bus port.
- Uses the same req / addr_ok / data_ok protocol as the core's memory ports.
- Tracks outstanding transactions in an in-order ID FIFO so that each downstream data_ok and rdata is routed back to the issuing channel.
- Sits between the core top and the single system memory/bus interface.

Parameters:
- XLEN, 32, data/address width.
- N_CH, 2, number of upstream request channels; channel 0 is highest fixed priority.
- OUTSTANDING, 2, maximum accepted-but-unanswered downstream transactions (FIFO depth, power of 2, >=1).
- IDW, $clog2(N_CH) with minimum 1, derived; channel ID width.

Ports:
- clk  input  1  clock.
- rst_b  input  1  reset, asynchronous, active-low.
- ch_req  input  N_CH  per-channel request.
- ch_write  input  N_CH  per-channel write flag.
- ch_wstrb  input  N_CH*XLEN/8  per-channel byte strobes, channel i at [i*XLEN/8 +: XLEN/8].
- ch_addr  input  N_CH*XLEN  per-channel address.
- ch_wdata  input  N_CH*XLEN  per-channel write data.
- ch_addr_ok  output  N_CH  address-phase accept, one-hot or zero.
- ch_data_ok  output  N_CH  response strobe, one-hot or zero.
- ch_rdata  output  XLEN  response data, shared by all channels, valid with ch_data_ok.
- bus_req  output  1  downstream request.
- bus_write  output  1  downstream write flag.
- bus_wstrb  output  XLEN/8  downstream byte strobes.
- bus_addr  output  XLEN  downstream address.
- bus_wdata  output  XLEN  downstream write data.
- bus_addr_ok  input  1  downstream address accept.
- bus_data_ok  input  1  downstream response.
- bus_rdata  input  XLEN  downstream read data.
- bus_idle  output  1  high when FIFO empty and no lock held.

Behaviour:
- Protocol:
  - Address handshake occurs when req && addr_ok in the same cycle.
  - Responses return in acceptance order, one data_ok per request (reads and writes).
  - bus_data_ok never arrives in the same cycle as the addr_ok of the transaction it answers.
- State machine (registered): IDLE, LOCK.
  - IDLE:
    - If FIFO not full and any ch_req is set, grant the winner combinationally and drive bus_* from the winner's ch_* fields.
    - If bus_addr_ok is also high: push the winner's ID, pulse ch_addr_ok[winner], stay in IDLE.
    - Otherwise register the winner as lock_id and go to LOCK.
  - LOCK:
    - The grant is held on lock_id regardless of other requests, because the downstream req must stay stable until addr_ok.
    - On bus_addr_ok: push lock_id, pulse ch_addr_ok[lock_id], return to IDLE.
    - If ch_req[lock_id] drops before accept (protocol violation), return to IDLE and flag it with an assertion.
- Full FIFO:
  - bus_req is forced low in IDLE.
  - A pop in the same cycle does not free a slot until the next cycle.
  - The FIFO never fills while in LOCK: entry to LOCK requires not-full, and there are no pushes while locked.
- Response routing:
  - On bus_data_ok, pop the FIFO head.
  - ch_data_ok[head] = 1 in the same cycle (zero-latency, combinational).
  - ch_rdata = bus_rdata.
  - bus_data_ok with an empty FIFO is ignored and fires an assertion.
- Simultaneous push and pop is legal; occupancy is unchanged.
- FIFO pointers are IDW-independent, log2(OUTSTANDING)+1 bits each; the MSB distinguishes full from empty.
- Zero grant latency: the request is visible on bus_* in the same cycle as ch_req.
- Reset (asynchronous, any time):
  - State = IDLE, FIFO empty, lock_id = 0, priority pointer = 0.
  - Outputs: ch_addr_ok = 0, ch_data_ok = 0, bus_req = 0, bus_idle = 1.
  - Other bus_* fields are don't-care while bus_req = 0.
  - Transactions in flight at reset are discarded.

Optional Feature:
- Macro: ARB_ROUND_ROBIN_EN.
- Defined: round-robin arbitration.
  - Priority starts at the channel after the last accepted one.
  - The pointer updates only on an address handshake, never while in LOCK.
- Undefined: fixed priority, lowest index wins; no priority pointer register.

Test Plan:
- Single channel, N_CH=2, ch_req=01, read addr 0x100, bus_addr_ok the same cycle, bus_data_ok 2 cycles later with rdata 0xDEADBEEF -> ch_addr_ok=01 in cycle 0, ch_data_ok=01 with ch_rdata=0xDEADBEEF in cycle 2, bus_idle returns to 1.
- Lock:
  - Stimulus: ch_req=01; bus_addr_ok held low 3 cycles; ch_req becomes 11 in cycle 1.
  - Response: bus_addr tracks channel 0 for all 4 cycles; channel 1 is granted only after channel 0's accept.
- Full FIFO:
  - Stimulus: OUTSTANDING=2; two accepted reads with no responses; third request.
  - Response: bus_req=0 until the first bus_data_ok; the third request is accepted the cycle after the pop.
- Ordering:
  - Stimulus: accept ch1 then ch0; two bus_data_ok with rdata A, B.
  - Response: ch_data_ok=10 with A, then 01 with B.
- Arbitration:
  - Stimulus: ch_req=11 held continuously, bus_addr_ok always 1, for 4 handshakes.
  - Response with ARB_ROUND_ROBIN_EN defined: grants 0,1,0,1.
  - Response without it: grants 0,0,0,0.
- Reset mid-operation: rst_b low while in LOCK with 1 entry in the FIFO -> bus_req=0 and bus_idle=1 immediately; a stray bus_data_ok after reset produces no ch_data_ok.

Source files
------------

// File: rtl/core_bus_arbiter.sv
// N-channel req/addr_ok/data_ok arbiter onto one bus port with an in-order ID FIFO for response routing.
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise the lowest index wins.
module core_bus_arbiter #(
  parameter int XLEN        = 32,
  parameter int N_CH        = 2,
  parameter int OUTSTANDING = 2,
  parameter int IDW         = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                     clk,
  input  logic                     rst_b,
  input  logic [N_CH-1:0]          ch_req,
  input  logic [N_CH-1:0]          ch_write,
  input  logic [N_CH*XLEN/8-1:0]   ch_wstrb,
  input  logic [N_CH*XLEN-1:0]     ch_addr,
  input  logic [N_CH*XLEN-1:0]     ch_wdata,
  output logic [N_CH-1:0]          ch_addr_ok,
  output logic [N_CH-1:0]          ch_data_ok,
  output logic [XLEN-1:0]          ch_rdata,
  output logic                     bus_req,
  output logic                     bus_write,
  output logic [XLEN/8-1:0]        bus_wstrb,
  output logic [XLEN-1:0]          bus_addr,
  output logic [XLEN-1:0]          bus_wdata,
  input  logic                     bus_addr_ok,
  input  logic                     bus_data_ok,
  input  logic [XLEN-1:0]          bus_rdata,
  output logic                     bus_idle
);

  localparam int SW = XLEN / 8;
  localparam int PW = $clog2(OUTSTANDING) + 1;
  localparam int MW = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;

  typedef enum logic {IDLE, LOCK} state_t;

  state_t          state_q, state_d;
  logic [IDW-1:0]  lock_id_q;
  logic [IDW-1:0]  win_id, grant_id, head_id;
  logic            win_valid;
  logic            handshake, push, pop, full, empty;
  logic [PW-1:0]   wr_ptr, rd_ptr, occupancy;
  logic [MW-1:0]   wr_idx, rd_idx;
  logic [IDW-1:0]  fifo_mem [OUTSTANDING];

`ifdef ARB_ROUND_ROBIN_EN
  logic [IDW-1:0]  rr_ptr;

  always_comb begin
    win_valid = 1'b0;
    win_id    = '0;
    for (int unsigned k = 0; k < N_CH; k++) begin
      logic [IDW-1:0] cand;
      cand = IDW'((int unsigned'(rr_ptr) + k) % N_CH);
      if (!win_valid && ch_req[cand]) begin
        win_valid = 1'b1;
        win_id    = cand;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b)
      rr_ptr <= '0;
    else if (handshake)
      rr_ptr <= (grant_id == IDW'(N_CH - 1)) ? '0 : grant_id + 1'b1;
  end
`else
  // Scan downward so the lowest requesting index is the last assignment.
  always_comb begin
    win_valid = 1'b0;
    win_id    = '0;
    for (int unsigned i = N_CH; i > 0; i--) begin
      if (ch_req[IDW'(i - 1)]) begin
        win_valid = 1'b1;
        win_id    = IDW'(i - 1);
      end
    end
  end
`endif

  assign occupancy = wr_ptr - rd_ptr;
  assign full      = (occupancy == PW'(OUTSTANDING));
  assign empty     = (wr_ptr == rd_ptr);
  assign wr_idx    = MW'(wr_ptr) & MW'(OUTSTANDING - 1);
  assign rd_idx    = MW'(rd_ptr) & MW'(OUTSTANDING - 1);
  assign head_id   = fifo_mem[rd_idx];

  // Request is qualified by rst_b so bus_req drops the instant reset asserts.
  always_comb begin
    state_d  = state_q;
    grant_id = win_id;
    bus_req  = 1'b0;
    unique case (state_q)
      IDLE: begin
        bus_req = rst_b && !full && win_valid;
        if (bus_req && !bus_addr_ok)
          state_d = LOCK;
      end
      LOCK: begin
        grant_id = lock_id_q;
        bus_req  = rst_b && ch_req[lock_id_q];
        if (!ch_req[lock_id_q] || bus_addr_ok)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus_write = 1'b0;
    bus_wstrb = '0;
    bus_addr  = '0;
    bus_wdata = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (grant_id == IDW'(i)) begin
        bus_write = ch_write[i];
        bus_wstrb = ch_wstrb[i*SW +: SW];
        bus_addr  = ch_addr[i*XLEN +: XLEN];
        bus_wdata = ch_wdata[i*XLEN +: XLEN];
      end
    end
  end

  assign handshake  = bus_req && bus_addr_ok;
  assign push       = handshake;
  assign pop        = bus_data_ok && !empty;
  assign ch_addr_ok = handshake ? (N_CH'(1) << grant_id) : '0;
  assign ch_data_ok = pop ? (N_CH'(1) << head_id) : '0;
  assign ch_rdata   = bus_rdata;
  assign bus_idle   = empty && (state_q == IDLE);

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q   <= IDLE;
      lock_id_q <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && bus_req && !bus_addr_ok)
        lock_id_q <= win_id;
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      fifo_mem[wr_idx] <= grant_id;
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (rst_b) begin
      assert (!(state_q == LOCK && !ch_req[lock_id_q]))
        else $error("core_bus_arbiter: request withdrawn before address accept");
      assert (!(bus_data_ok && empty))
        else $error("core_bus_arbiter: bus_data_ok with no outstanding transaction");
    end
  end
`endif

endmodule
